ebi_bus_interface: RTL and testbench
====================================

EBI_BUS_INTERFACE -- requirements
Module: ebi_bus_interface

Interface
REQ-001 SYNC_STAGES, default 2, synchronizer depth applied to every EBI input (legal values 2..3).
REQ-002 clk  input  1  100 MHz system clock; the only clock in the block.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 EBI_AD_in  input  16  multiplexed address/data bus from the MCU, asynchronous.
REQ-005 EBI_ALE  input  1  address latch enable, active-low, asynchronous; idles high.
REQ-006 EBI_WE  input  1  write enable, active-low, asynchronous; idles high.
REQ-007 EBI_RE  input  1  read enable, active-low, asynchronous; idles high.
REQ-008 bank_select  input  3  target bank (0 OAM, 1 sprite, 2 palette, 3 TAM, 4 control, 5-7 unmapped), asynchronous.
REQ-009 vga_frame_done  input  1  one-clk pulse from the display pipeline at end of visible frame.
REQ-010 EBI_AD_out  output  16  read data for the bus.
REQ-011 EBI_AD_oe  output  1  bus output enable; the top-level tristate drives EBI_AD only when high.
REQ-012 oam_we, sprite_we, palette_we, tam_we  output  1 each  one-clk write strobes.
REQ-013 wr_addr  output  16  latched bus address, valid while any *_we is high.
REQ-014 wr_data  output  16  captured write data, valid while any *_we is high.

Function
REQ-015 All EBI inputs (AD, ALE, WE, RE, bank_select) SHALL pass through SYNC_STAGES flip-flops; all logic below uses only the synchronized copies.
REQ-016 The FSM SHALL have states IDLE, ADDR, DATA, WRITE, READ.
REQ-017 IDLE -> ADDR when synced ALE is low.
REQ-018 ADDR -> DATA when synced ALE goes high; address register SHALL take the synced AD value from the cycle before the rising edge was seen.
REQ-019 DATA -> WRITE when synced WE is low; DATA -> READ when synced RE is low; DATA -> ADDR when synced ALE is low again (previous address discarded, no strobe).
REQ-020 If WE and RE are seen low in the same cycle in DATA, WRITE SHALL win.
REQ-021 WRITE: wr_data SHALL track synced AD each cycle; on synced WE rising edge, exactly one strobe fires for one clk, then state goes to IDLE.
REQ-022 The strobe SHALL be selected by bank_select sampled on the WE rising edge; banks 4-7 SHALL produce no memory strobe.
REQ-023 Pin-level latency: strobe high on the (SYNC_STAGES+1)-th rising clk after the WE pin rises.
REQ-024 Control bank (4), address 0x0000 write: bit 0 = 1 clears frame_flag; other bits and addresses are ignored.
REQ-025 frame_flag SHALL set on vga_frame_done; when set and clear occur in the same cycle, set SHALL win.
REQ-026 READ: EBI_AD_oe SHALL be high from the cycle after entry until the cycle synced RE is seen high, then state goes to IDLE.
REQ-027 Read data: bank 4 address 0 returns {15'b0, frame_flag}; bank 4 address 1 returns 16'hBEEF (ID); all other reads return 0.
REQ-028 Reading bank 4 address 0 SHALL clear frame_flag when READ exits, unless vga_frame_done pulses in that same cycle.
REQ-029 Strobes SHALL be mutually exclusive, and none SHALL fire outside WRITE exit.
REQ-030 Address 0xFFFF SHALL be passed through unmodified; there is no address wrap or range checking in this block.

Reset
REQ-031 While reset is high: state IDLE; all *_we = 0; EBI_AD_oe = 0; EBI_AD_out = 0; wr_addr = 0; wr_data = 0; frame_flag = 0; synchronizers = idle values (ALE/WE/RE = 1, AD = 0).
REQ-032 Reset asserted mid-transaction SHALL abort it without any strobe, and SHALL drop EBI_AD_oe on the next clk.
REQ-033 After reset releases, a WE/RE already low SHALL NOT be acted on until a fresh ALE cycle occurs.

Verification
REQ-034 ALE low with AD=0x0012, then ALE high; WE low with AD=0x00A5, bank=0; WE high -> oam_we single pulse, wr_addr=0x0012, wr_data=0x00A5, SYNC_STAGES+1 clks after WE rise.
REQ-035 Same write sequence for bank_select = 1, 2, 3, 5 -> sprite_we, palette_we, tam_we respectively, each exactly once; bank 5 gives no strobe.
REQ-036 Pulse vga_frame_done, then read bank 4 addr 0 -> EBI_AD_out=0x0001 with oe high during RE; a second read returns 0x0000.
REQ-037 vga_frame_done pulse coincides with the clearing READ exit -> the next read still returns 0x0001.
REQ-038 Assert reset in the middle of a WRITE (WE low) -> no strobe, all outputs 0; WE released after reset -> still no strobe.
REQ-039 Read bank 4 addr 1 -> 0xBEEF; read bank 0 -> 0x0000; ALE re-asserted in DATA -> new address used, no strobe for the abandoned cycle.

Source files
------------

// File: rtl/ebi_bus_interface.sv
// rtl/ebi_bus_interface.sv - MCU external bus slave: synchronizers, address/data FSM, write strobes, control readback.
module ebi_bus_interface #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] EBI_AD_in,
   input  logic        EBI_ALE,
   input  logic        EBI_WE,
   input  logic        EBI_RE,
   input  logic [2:0]  bank_select,
   input  logic        vga_frame_done,
   output logic [15:0] EBI_AD_out,
   output logic        EBI_AD_oe,
   output logic        oam_we,
   output logic        sprite_we,
   output logic        palette_we,
   output logic        tam_we,
   output logic [15:0] wr_addr,
   output logic [15:0] wr_data
);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE, READ} state_t;

   // Packed pin bundle {bank, RE, WE, ALE, AD}; strobes idle high
   localparam logic [21:0] SYNC_IDLE = {3'b000, 3'b111, 16'h0000};

   logic [21:0] sync_q [SYNC_STAGES];
   logic [21:0] sync_s;
   logic [15:0] ad_s;
   logic        ale_s, we_s, re_s;
   logic [2:0]  bank_s;

   state_t      state_q, state_d;
   logic [15:0] ad_prev_q;
   logic [15:0] wr_addr_q, wr_addr_d;
   logic [15:0] wr_data_q, wr_data_d;
   logic [3:0]  strobe_q, strobe_d;
   logic        oe_q, oe_d;
   logic [15:0] out_q, out_d;
   logic        flag_q, flag_d;
   logic        flag_clr;
   logic [15:0] rdata;
   logic        ctrl_addr0;

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_IDLE;
      end else begin
         sync_q[0] <= {bank_select, EBI_RE, EBI_WE, EBI_ALE, EBI_AD_in};
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync_s = sync_q[SYNC_STAGES-1];
   assign ad_s   = sync_s[15:0];
   assign ale_s  = sync_s[16];
   assign we_s   = sync_s[17];
   assign re_s   = sync_s[18];
   assign bank_s = sync_s[21:19];

   assign ctrl_addr0 = (bank_s == 3'd4) && (wr_addr_q == 16'h0000);

   always_comb begin
      rdata = 16'h0000;
      if (ctrl_addr0) rdata = {15'b0, flag_q};
      else if (bank_s == 3'd4 && wr_addr_q == 16'h0001) rdata = 16'hBEEF;
   end

   always_comb begin
      state_d   = state_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      strobe_d  = 4'b0000;
      flag_clr  = 1'b0;
      case (state_q)
         IDLE:  if (!ale_s) state_d = ADDR;
         ADDR: begin
            if (ale_s) begin
               state_d   = DATA;
               wr_addr_d = ad_prev_q;
            end
         end
         DATA: begin
            // WE outranks RE when both are seen in the same cycle
            if (!we_s)       state_d = WRITE;
            else if (!re_s)  state_d = READ;
            else if (!ale_s) state_d = ADDR;
         end
         WRITE: begin
            if (we_s) begin
               state_d = IDLE;
               if (!bank_s[2]) strobe_d[bank_s[1:0]] = 1'b1;
               else if (ctrl_addr0 && wr_data_q[0]) flag_clr = 1'b1;
            end else begin
               wr_data_d = ad_s;
            end
         end
         READ: begin
            if (re_s) begin
               state_d  = IDLE;
               flag_clr = ctrl_addr0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign oe_d   = (state_q == READ) && !re_s;
   assign out_d  = oe_d ? rdata : 16'h0000;
   assign flag_d = vga_frame_done | (flag_q & ~flag_clr);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         ad_prev_q <= 16'h0000;
         wr_addr_q <= 16'h0000;
         wr_data_q <= 16'h0000;
         strobe_q  <= 4'b0000;
         oe_q      <= 1'b0;
         out_q     <= 16'h0000;
         flag_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ad_prev_q <= ad_s;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         strobe_q  <= strobe_d;
         oe_q      <= oe_d;
         out_q     <= out_d;
         flag_q    <= flag_d;
      end
   end

   assign EBI_AD_out = out_q;
   assign EBI_AD_oe  = oe_q;
   assign oam_we     = strobe_q[0];
   assign sprite_we  = strobe_q[1];
   assign palette_we = strobe_q[2];
   assign tam_we     = strobe_q[3];
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;

endmodule

// File: tb/tb_ebi_bus_interface.sv
// tb/tb_ebi_bus_interface.sv - self-checking bench for ebi_bus_interface.
module tb_ebi_bus_interface;

   localparam int SYNC = 2;

   logic        clk;
   logic        reset;
   logic [15:0] EBI_AD_in;
   logic        EBI_ALE, EBI_WE, EBI_RE;
   logic [2:0]  bank_select;
   logic        vga_frame_done;
   logic [15:0] EBI_AD_out;
   logic        EBI_AD_oe;
   logic        oam_we, sprite_we, palette_we, tam_we;
   logic [15:0] wr_addr, wr_data;

   ebi_bus_interface #(.SYNC_STAGES(SYNC)) dut (
      .clk(clk), .reset(reset), .EBI_AD_in(EBI_AD_in), .EBI_ALE(EBI_ALE),
      .EBI_WE(EBI_WE), .EBI_RE(EBI_RE), .bank_select(bank_select),
      .vga_frame_done(vga_frame_done), .EBI_AD_out(EBI_AD_out), .EBI_AD_oe(EBI_AD_oe),
      .oam_we(oam_we), .sprite_we(sprite_we), .palette_we(palette_we), .tam_we(tam_we),
      .wr_addr(wr_addr), .wr_data(wr_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int strobe_pulses = 0;
   int multi_hot = 0;
   int exp_pulses = 0;
   bit model_flag = 1'b0;

   typedef struct {
      logic [2:0]  bank;
      logic [15:0] addr;
      logic [15:0] data;
      logic [3:0]  exp_we;
   } wvec_t;

   wvec_t tbl[7];

   always @(negedge clk) begin
      int n;
      n = int'(oam_we === 1'b1) + int'(sprite_we === 1'b1) + int'(palette_we === 1'b1) + int'(tam_we === 1'b1);
      strobe_pulses += n;
      if (n > 1) multi_hot++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] ref_read(input logic [2:0] b, input logic [15:0] a);
      if (b == 3'd4 && a == 16'h0000) return {15'b0, model_flag};
      if (b == 3'd4 && a == 16'h0001) return 16'hBEEF;
      return 16'h0000;
   endfunction

   task automatic addr_phase(input logic [2:0] b, input logic [15:0] a);
      @(negedge clk);
      EBI_ALE = 1'b0; EBI_AD_in = a; bank_select = b;
      repeat (4) @(negedge clk);
      EBI_ALE = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic frame_pulse();
      @(negedge clk); vga_frame_done = 1'b1;
      @(negedge clk); vga_frame_done = 1'b0;
      model_flag = 1'b1;
   endtask

   task automatic do_write(input logic [2:0] b, input logic [15:0] a, input logic [15:0] d,
                           input logic [3:0] exp_v, input bit decoy);
      logic [3:0]  got_v, at_v;
      logic [15:0] a_at, d_at;
      int          stray;
      stray = 0; at_v = 4'h0; a_at = 16'h0; d_at = 16'h0;
      if (decoy) addr_phase(b, ~a);
      addr_phase(b, a);
      EBI_AD_in = d; EBI_WE = 1'b0;
      repeat (5) @(negedge clk);
      EBI_WE = 1'b1;
      for (int k = 1; k <= SYNC + 3; k++) begin
         @(posedge clk); #1;
         got_v = {tam_we, palette_we, sprite_we, oam_we};
         if (k == SYNC + 1) begin
            at_v = got_v; a_at = wr_addr; d_at = wr_data;
         end else if (got_v !== 4'b0000) begin
            stray++;
         end
      end
      check("strobe_at_latency", 32'(at_v), 32'(exp_v));
      check("strobe_stray_edges", 32'(stray), 32'd0);
      if (exp_v != 4'b0000) begin
         check("wr_addr", 32'(a_at), 32'(a));
         check("wr_data", 32'(d_at), 32'(d));
         exp_pulses++;
      end
      if (b == 3'd4 && a == 16'h0000 && d[0]) model_flag = 1'b0;
      @(negedge clk);
      EBI_AD_in = 16'h0000;
   endtask

   task automatic do_read(input logic [2:0] b, input logic [15:0] a, input logic [15:0] exp_d,
                          input bit done_at_exit);
      logic [31:0] r32;
      addr_phase(b, a);
      r32 = $urandom;
      EBI_RE = 1'b0; EBI_AD_in = r32[15:0];
      repeat (6) @(negedge clk);
      check("read_oe_high", 32'(EBI_AD_oe), 32'd1);
      check("read_data", 32'(EBI_AD_out), 32'(exp_d));
      EBI_RE = 1'b1;
      if (done_at_exit) begin
         repeat (SYNC) @(posedge clk);
         @(negedge clk); vga_frame_done = 1'b1;
         @(negedge clk); vga_frame_done = 1'b0;
         repeat (3) @(negedge clk);
      end else begin
         repeat (5) @(negedge clk);
      end
      check("read_oe_dropped", {15'b0, EBI_AD_oe, EBI_AD_out}, 32'd0);
      if (b == 3'd4 && a == 16'h0000) model_flag = done_at_exit;
      EBI_AD_in = 16'h0000;
   endtask

   initial begin
      logic [31:0] r32;
      logic [2:0]  rb;
      logic [15:0] ra, rd;

      tbl[0] = '{3'd0, 16'h0012, 16'h00A5, 4'b0001};
      tbl[1] = '{3'd1, 16'h0012, 16'h00A5, 4'b0010};
      tbl[2] = '{3'd2, 16'h0012, 16'h00A5, 4'b0100};
      tbl[3] = '{3'd3, 16'h0012, 16'h00A5, 4'b1000};
      tbl[4] = '{3'd5, 16'h0012, 16'h00A5, 4'b0000};
      tbl[5] = '{3'd0, 16'hFFFF, 16'h5A5A, 4'b0001};
      tbl[6] = '{3'd4, 16'h0002, 16'hFFFF, 4'b0000};

      reset = 1'b1; EBI_AD_in = 16'h0000; EBI_ALE = 1'b1; EBI_WE = 1'b1; EBI_RE = 1'b1;
      bank_select = 3'd0; vga_frame_done = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_strobes_oe", {27'b0, EBI_AD_oe, tam_we, palette_we, sprite_we, oam_we}, 32'd0);
      check("rst_ad_out", 32'(EBI_AD_out), 32'd0);
      check("rst_wr_addr", 32'(wr_addr), 32'd0);
      check("rst_wr_data", 32'(wr_data), 32'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 7; i++) do_write(tbl[i].bank, tbl[i].addr, tbl[i].data, tbl[i].exp_we, 1'b0);

      frame_pulse();
      do_read(3'd4, 16'h0000, 16'h0001, 1'b0);
      do_read(3'd4, 16'h0000, 16'h0000, 1'b0);
      frame_pulse();
      do_read(3'd4, 16'h0000, 16'h0001, 1'b1);
      do_read(3'd4, 16'h0000, 16'h0001, 1'b0);
      do_read(3'd4, 16'h0000, 16'h0000, 1'b0);
      do_read(3'd4, 16'h0001, 16'hBEEF, 1'b0);
      do_read(3'd0, 16'h0012, 16'h0000, 1'b0);
      do_write(3'd2, 16'h0345, 16'h6789, 4'b0100, 1'b1);

      frame_pulse();
      do_write(3'd4, 16'h0000, 16'h0002, 4'b0000, 1'b0);
      do_read(3'd4, 16'h0000, 16'h0001, 1'b0);
      frame_pulse();
      do_write(3'd4, 16'h0000, 16'h0001, 4'b0000, 1'b0);
      do_read(3'd4, 16'h0000, 16'h0000, 1'b0);

      // Reset in the middle of a write, WE still low across release
      frame_pulse();
      addr_phase(3'd0, 16'h0042);
      EBI_AD_in = 16'h1111; EBI_WE = 1'b0;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midwr_rst_strobes", {28'b0, tam_we, palette_we, sprite_we, oam_we}, 32'd0);
      check("midwr_rst_wr_addr", 32'(wr_addr), 32'd0);
      check("midwr_rst_wr_data", 32'(wr_data), 32'd0);
      model_flag = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      EBI_WE = 1'b1;
      repeat (10) @(negedge clk);
      check("midwr_no_strobe", 32'(strobe_pulses), 32'(exp_pulses));
      do_read(3'd4, 16'h0000, 16'h0000, 1'b0);

      // Reset in the middle of a read, RE still low across release
      addr_phase(3'd4, 16'h0001);
      EBI_RE = 1'b0;
      repeat (6) @(negedge clk);
      check("midrd_oe_before", 32'(EBI_AD_oe), 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("midrd_oe_dropped", {15'b0, EBI_AD_oe, EBI_AD_out}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("midrd_no_reentry", 32'(EBI_AD_oe), 32'd0);
      EBI_RE = 1'b1;
      repeat (3) @(negedge clk);

      for (int i = 0; i < 24; i++) begin
         r32 = $urandom;
         rb = r32[2:0];
         ra = r32[18] ? {15'b0, r32[3]} : r32[31:16];
         r32 = $urandom;
         rd = r32[15:0];
         case (r32[17:16])
            2'd0: do_write(rb, ra, rd, rb < 3'd4 ? 4'b0001 << rb : 4'b0000, r32[20]);
            2'd1: do_read(rb, ra, ref_read(rb, ra), 1'b0);
            2'd2: do_write(3'd4, 16'h0000, rd, 4'b0000, 1'b0);
            default: begin
               if (r32[21]) frame_pulse();
               do_read(3'd4, 16'h0000, ref_read(3'd4, 16'h0000), r32[22]);
            end
         endcase
      end

      repeat (5) @(negedge clk);
      check("total_strobe_pulses", 32'(strobe_pulses), 32'(exp_pulses));
      check("strobes_exclusive", 32'(multi_hot), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
